// File: rtl/alu_stream_pkg.sv
// Shared command encodings for alu_stream and its neighbours in the datapath.
package alu_stream_pkg;

  // The legacy 3-bit encoding is the low three bits of these codes.
  localparam logic [3:0] COMMAND_ADD  = 4'd0;
  localparam logic [3:0] COMMAND_SUB  = 4'd1;
  localparam logic [3:0] COMMAND_XOR  = 4'd2;
  localparam logic [3:0] COMMAND_SLT  = 4'd3;
  localparam logic [3:0] COMMAND_AND  = 4'd4;
  localparam logic [3:0] COMMAND_NAND = 4'd5;
  localparam logic [3:0] COMMAND_NOR  = 4'd6;
  localparam logic [3:0] COMMAND_OR   = 4'd7;
  localparam logic [3:0] COMMAND_MUL  = 4'd8;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per step, WIDTH-1 steps plus a
// combinational final step, so the full product is available when done_o rises.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      count_d  = CW'(WIDTH - 1);
    end else if (step_i && (count_q != '0)) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  // The last multiplier bit is folded in here, so a stalled result stays stable.
  assign done_o    = (count_q == '0);
  assign product_o = acc_q + (mplier_q[0] ? mcand_q : '0);

endmodule

// File: rtl/alu_stream.sv
// Handshaked ALU with a registered output stage and backpressure.
// Define ALU_STREAM_MUL_EN to include the multi-cycle MUL command.
module alu_stream
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, ovf_q;

  logic             can_load, accept, load_en;
  logic [WIDTH-1:0] load_res;
  logic             load_c, load_o;

  logic [WIDTH-1:0] b_eff, alu_res;
  logic [WIDTH:0]   sum;
  logic             add_ovf, alu_c, alu_o;

  assign can_load = !out_valid_q || out_ready;

  // One adder serves ADD, SUB and SLT; anything but ADD subtracts.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    b_eff   = (command == COMMAND_ADD) ? operand_b : ~operand_b;
    sum     = {1'b0, operand_a} + {1'b0, b_eff} + (WIDTH+1)'(command != COMMAND_ADD);
    add_ovf = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
    case (command)
      COMMAND_ADD, COMMAND_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = add_ovf;
      end
      COMMAND_SLT:  alu_res = WIDTH'(sum[WIDTH-1] ^ add_ovf);
      COMMAND_XOR:  alu_res = operand_a ^ operand_b;
      COMMAND_AND:  alu_res = operand_a & operand_b;
      COMMAND_NAND: alu_res = ~(operand_a & operand_b);
      COMMAND_NOR:  alu_res = ~(operand_a | operand_b);
      COMMAND_OR:   alu_res = operand_a | operand_b;
      COMMAND_MUL:  alu_res = '0;
      default:      alu_res = '0;
    endcase
  end

`ifdef ALU_STREAM_MUL_EN
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t             state_q, state_d;
  logic               is_mul, mul_start, mul_step, mul_done, mul_load;
  logic [2*WIDTH-1:0] mul_product;

  assign is_mul    = (command == COMMAND_MUL);
  assign in_ready  = (state_q == IDLE) && can_load;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign mul_step  = (state_q == MUL_RUN);
  assign mul_load  = mul_step && mul_done && can_load;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .step_i    (mul_step),
    .a_i       (operand_a),
    .b_i       (operand_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL_RUN;
      MUL_RUN: if (mul_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    load_en  = (accept && !is_mul) || mul_load;
    load_res = alu_res;
    load_c   = alu_c;
    load_o   = alu_o;
    if (mul_load) begin
      load_res = mul_product[WIDTH-1:0];
      load_c   = 1'b0;
      load_o   = |mul_product[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign in_ready = can_load;
  assign accept   = in_valid && in_ready;
  assign load_en  = accept;
  assign load_res = alu_res;
  assign load_c   = alu_c;
  assign load_o   = alu_o;
`endif

  // A load on a consume edge keeps out_valid high with the new result.
  always_comb begin
    out_valid_d = out_valid_q;
    if (load_en)        out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_en) begin
        result_q <= load_res;
        carry_q  <= load_c;
        zero_q   <= (load_res == '0);
        ovf_q    <= load_o;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carryout  = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_stream.sv
// Directed self-checking bench for alu_stream (WIDTH 32); MUL cases follow ALU_STREAM_MUL_EN.
module tb_alu_stream;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   command;
  logic [W-1:0] operand_a, operand_b, result;
  logic         carryout, zero, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   cmd;
    logic [W-1:0] a, b, res;
    logic         c, z, o;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_stream #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryout(carryout), .zero(zero), .overflow(overflow)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; command = 4'd0;
    operand_a = '0; operand_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result, carryout, zero, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h c=%b z=%b o=%b want 1 0 0 0 0 0",
               in_ready, out_valid, result, carryout, zero, overflow);
    end
    $display("txn reset in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Back-to-back stream, one op per cycle; each result is checked one cycle after its request.
  task automatic test_alu_ops();
    vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{4'd1, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{4'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd3, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd15, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        checks++;
        if ({out_valid, result, carryout, zero, overflow} !==
            {1'b1, vecs[i-1].res, vecs[i-1].c, vecs[i-1].z, vecs[i-1].o}) begin
          errors++;
          $display("FAIL op%0d cmd=%0d: got v=%b r=%h c=%b z=%b o=%b want v=1 r=%h c=%b z=%b o=%b",
                   i-1, vecs[i-1].cmd, out_valid, result, carryout, zero, overflow,
                   vecs[i-1].res, vecs[i-1].c, vecs[i-1].z, vecs[i-1].o);
        end
        $display("txn op cmd=%0d a=%h b=%h result=%h c=%b z=%b o=%b", vecs[i-1].cmd,
                 vecs[i-1].a, vecs[i-1].b, result, carryout, zero, overflow);
      end
      if (i < 12) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL op%0d_in_ready: got %b want 1", i, in_ready);
        end
        in_valid = 1'b1; command = vecs[i].cmd;
        operand_a = vecs[i].a; operand_b = vecs[i].b;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; command = 4'd0; operand_a = 32'd1; operand_b = 32'd2;
    @(negedge clk);
    operand_a = 32'd5; operand_b = 32'd6;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({out_valid, result, in_ready} !== {1'b1, 32'd3, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b r=%h in_ready=%b want v=1 r=3 in_ready=0",
                 k, out_valid, result, in_ready);
      end
      $display("txn bp_hold%0d result=%h in_ready=%b", k, result, in_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 32'd11}) begin
      errors++;
      $display("FAIL bp_second: got v=%b r=%h want v=1 r=0000000b", out_valid, result);
    end
    $display("txn bp_second result=%h", result);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    end
  endtask

`ifdef ALU_STREAM_MUL_EN
  task automatic test_mul();
    logic [W-1:0] ma[2], mb[2], mr[2];
    logic         mo[2], mz[2];
    int           bad;
    ma[0] = 32'h0000FFFF; mb[0] = 32'h00010001; mr[0] = 32'hFFFFFFFF; mo[0] = 1'b0; mz[0] = 1'b0;
    ma[1] = 32'h00010000; mb[1] = 32'h00010000; mr[1] = 32'h00000000; mo[1] = 1'b1; mz[1] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL mul%0d_accept: in_ready=%b want 1", i, in_ready);
      end
      in_valid = 1'b1; command = 4'd8; operand_a = ma[i]; operand_b = mb[i];
      @(negedge clk);
      in_valid = 1'b0; operand_a = 32'hDEADBEEF; operand_b = 32'h12345678;
      bad = 0;
      for (int k = 1; k <= W; k++) begin
        if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL mul%0d_busy: %0d of %0d cycles had in_ready/out_valid high, want 0", i, bad, W);
      end
      checks++;
      if ({out_valid, result, carryout, zero, overflow} !== {1'b1, mr[i], 1'b0, mz[i], mo[i]}) begin
        errors++;
        $display("FAIL mul%0d: got v=%b r=%h c=%b z=%b o=%b want v=1 r=%h c=0 z=%b o=%b",
                 i, out_valid, result, carryout, zero, overflow, mr[i], mz[i], mo[i]);
      end
      $display("txn mul a=%h b=%h result=%h z=%b o=%b", ma[i], mb[i], result, zero, overflow);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_mul();
    out_ready = 1'b1;
    in_valid = 1'b1; command = 4'd8; operand_a = 32'd3; operand_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result, carryout, zero, overflow} !== {1'b1, 32'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL code8_unused: got v=%b r=%h c=%b z=%b o=%b want v=1 r=0 c=0 z=1 o=0",
               out_valid, result, carryout, zero, overflow);
    end
    $display("txn code8 result=%h zero=%b", result, zero);
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_op();
    int bad;
    out_ready = 1'b1;
    in_valid = 1'b1; command = 4'd0; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
`ifdef ALU_STREAM_MUL_EN
    command = 4'd8; operand_a = 32'd5; operand_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`else
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result, carryout, zero, overflow} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL midreset: in_ready=%b out_valid=%b result=%h c=%b z=%b o=%b want 1 0 0 0 0 0",
               in_ready, out_valid, result, carryout, zero, overflow);
    end
    $display("txn midreset result=%h out_valid=%b", result, out_valid);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; command = 4'd0; operand_a = 32'd1; operand_b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 32'd3}) begin
      errors++;
      $display("FAIL post_reset_add: got v=%b r=%h want v=1 r=3", out_valid, result);
    end
    $display("txn post_reset_add result=%h", result);
    bad = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stale_after_reset: out_valid high in %0d cycles, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_mul();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
